// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared timing defaults, bus widths and FSM state encoding
//               for the camera bus transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int C_H_ACTIVE = 640;
    localparam int C_V_ACTIVE = 480;
    localparam int C_H_BLANK  = 288;
    localparam int C_VS_LINES = 3;
    localparam int C_VBP      = 17;
    localparam int C_VFP      = 10;

    localparam int C_ADDR_W   = 19;
    localparam int C_PIX_W    = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cam_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : cam_timing_gen
// Description : Frame FSM, h/v counters and vsync/href/pixel decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_timing_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int H_BLANK  = C_H_BLANK,
    parameter int VS_LINES = C_VS_LINES,
    parameter int VBP      = C_VBP,
    parameter int VFP      = C_VFP
) (
    input  logic i_pclk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_run,
    output logic o_rd_strobe,
    output logic o_vs,
    output logic o_href,
    output logic o_first,
    output logic o_last_px,
    output logic o_frame_wrap
);

    localparam int LINE  = 2*H_ACTIVE + H_BLANK;
    localparam int FRAME = VS_LINES + VBP + V_ACTIVE + VFP;
    localparam int HW    = $clog2(LINE);
    localparam int VW    = $clog2(FRAME);

    localparam logic [HW-1:0] C_H_LAST    = HW'(LINE - 1);
    localparam logic [HW-1:0] C_H_ACT     = HW'(2*H_ACTIVE);
    localparam logic [HW-1:0] C_H_PX_LAST = HW'(2*H_ACTIVE - 1);
    localparam logic [VW-1:0] C_V_LAST    = VW'(FRAME - 1);
    localparam logic [VW-1:0] C_VS        = VW'(VS_LINES);
    localparam logic [VW-1:0] C_V_FIRST   = VW'(VS_LINES + VBP);
    localparam logic [VW-1:0] C_V_ACTLAST = VW'(VS_LINES + VBP + V_ACTIVE - 1);

    state_t          r_state, w_state_nxt;
    logic [HW-1:0]   r_h, w_h_nxt;
    logic [VW-1:0]   r_v, w_v_nxt;
    logic            w_h_wrap, w_v_wrap;

    function automatic logic f_href(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (h < C_H_ACT) && (v >= C_V_FIRST) && (v <= C_V_ACTLAST);
    endfunction

    assign w_h_wrap = (r_h == C_H_LAST);
    assign w_v_wrap = (r_v == C_V_LAST);

    // i_en only matters in IDLE or at the very last counter position
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
        case (r_state)
            ST_IDLE: if (i_en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_h_wrap) begin
                    if (w_v_wrap) begin
                        if (!i_en) w_state_nxt = ST_IDLE;
                    end else begin
                        w_v_nxt = r_v + 1'b1;
                    end
                end else begin
                    w_h_nxt = r_h + 1'b1;
                    w_v_nxt = r_v;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read strobe is decoded from the next counter value so it lines up with the counters
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_h         <= '0;
            r_v         <= '0;
            o_rd_strobe <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            o_rd_strobe <= (w_state_nxt == ST_RUN) && f_href(w_h_nxt, w_v_nxt) && !w_h_nxt[0];
        end
    end

    assign o_run        = (r_state == ST_RUN);
    assign o_vs         = o_run && (r_v < C_VS);
    assign o_href       = o_run && f_href(r_h, r_v);
    assign o_first      = o_href && !r_h[0];
    assign o_last_px    = o_run && (r_h == C_H_PX_LAST) && (r_v == C_V_ACTLAST);
    assign o_frame_wrap = o_run && w_h_wrap && w_v_wrap;

endmodule
`default_nettype wire

// File: rtl/camera_bus_tx.sv
`default_nettype none
// ============================================================================
// Module      : camera_bus_tx
// Description : Framebuffer reader driving an 8-bit DVP-style camera bus.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_bus_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int H_BLANK  = C_H_BLANK,
    parameter int VS_LINES = C_VS_LINES,
    parameter int VBP      = C_VBP,
    parameter int VFP      = C_VFP
) (
    input  logic                i_pclk,
    input  logic                i_rst,
    input  logic                i_en,
    output logic [C_ADDR_W-1:0] o_rd_addr,
    output logic                o_rd_en,
    input  logic [C_PIX_W-1:0]  i_rd_data,
    output logic                o_vsync,
    output logic                o_href,
    output logic [7:0]          o_D,
    output logic                o_frame_done
);

    logic w_run, w_rd_strobe, w_vs, w_href, w_first, w_last_px, w_frame_wrap;

    logic                r_vs1, r_href1, r_first1, r_last1, r_last2;
    logic [7:0]          r_gb;
    logic [C_ADDR_W-1:0] r_addr;

    cam_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .VBP      (VBP),
        .VFP      (VFP)
    ) u_timing (
        .i_pclk       (i_pclk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .o_run        (w_run),
        .o_rd_strobe  (w_rd_strobe),
        .o_vs         (w_vs),
        .o_href       (w_href),
        .o_first      (w_first),
        .o_last_px    (w_last_px),
        .o_frame_wrap (w_frame_wrap)
    );

    always_ff @(posedge i_pclk) begin
        if (i_rst || !w_run || w_frame_wrap) begin
            r_addr <= '0;
        end else if (w_rd_strobe) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Stage 1 carries the decodes while the RAM read is in flight; stage 2 is the pins
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_vs1        <= 1'b0;
            r_href1      <= 1'b0;
            r_first1     <= 1'b0;
            r_last1      <= 1'b0;
            r_last2      <= 1'b0;
            r_gb         <= '0;
            o_vsync      <= 1'b0;
            o_href       <= 1'b0;
            o_D          <= '0;
            o_frame_done <= 1'b0;
        end else begin
            r_vs1        <= w_vs;
            r_href1      <= w_href;
            r_first1     <= w_first;
            r_last1      <= w_last_px;
            r_last2      <= r_last1;
            o_frame_done <= r_last2;
            o_vsync      <= r_vs1;
            o_href       <= r_href1;
            if (r_first1) begin
                r_gb <= i_rd_data[7:0];
            end
            if (!r_href1) begin
                o_D <= '0;
            end else if (r_first1) begin
                o_D <= {4'b0000, i_rd_data[11:8]};
            end else begin
                o_D <= r_gb;
            end
        end
    end

    assign o_rd_en   = w_rd_strobe;
    assign o_rd_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_camera_bus_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_bus_tx
// Description : Scoreboard bench for camera_bus_tx with small frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_bus_tx;

    localparam int NPIX = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [18:0] rd_addr;
    logic        rd_en;
    logic [11:0] rd_data;
    logic        vsync, href, frame_done;
    logic [7:0]  d;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_seen = 0;

    int         addr_q[$];
    logic [7:0] byte_q[$];
    int         rdcyc_q[$];

    bit first_byte = 1'b1;
    bit prev_vs = 1'b0, prev_href = 1'b0, prev_done = 1'b0;
    bit vs_counting = 1'b0, vs_meas_done = 1'b0;
    int vs_rise = -1, vs_len = 0, href_delay = -1;

    camera_bus_tx #(
        .H_ACTIVE (4), .V_ACTIVE (3), .H_BLANK (4),
        .VS_LINES (1), .VBP (1), .VFP (1)
    ) dut (
        .i_pclk       (clk),
        .i_rst        (rst),
        .i_en         (en),
        .o_rd_addr    (rd_addr),
        .o_rd_en      (rd_en),
        .i_rd_data    (rd_data),
        .o_vsync      (vsync),
        .o_href       (href),
        .o_D          (d),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= 12'h100 + rd_addr[11:0];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame();
        logic [11:0] px;
        for (int n = 0; n < NPIX; n++) begin
            px = 12'h100 + 12'(n);
            addr_q.push_back(n);
            byte_q.push_back({4'b0000, px[11:8]});
            byte_q.push_back(px[7:0]);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && done_seen < target; i++) @(posedge clk);
        chk("frame_done_count", done_seen, target);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or a byte
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                if (addr_q.size() == 0) chk("unexpected_rd_en", 1, 0);
                else chk("rd_addr", int'(rd_addr), addr_q.pop_front());
                rdcyc_q.push_back(cyc);
            end
            if (href) begin
                if (byte_q.size() == 0) chk("unexpected_byte", 1, 0);
                else chk("pixel_byte", int'(d), int'(byte_q.pop_front()));
                if (first_byte) begin
                    if (rdcyc_q.size() == 0) chk("byte_without_rd", 1, 0);
                    else chk("rd_to_byte_latency", cyc - rdcyc_q.pop_front(), 2);
                end
                first_byte = !first_byte;
            end else begin
                chk("d_zero_outside_href", int'(d), 0);
            end
            if (frame_done) begin
                chk("frame_done_single_pulse", int'(prev_done), 0);
                done_seen++;
            end
            if (vsync && !prev_vs && !vs_meas_done) begin
                vs_rise = cyc;
                vs_counting = 1'b1;
            end
            if (vs_counting) begin
                if (vsync) vs_len++;
                else begin
                    vs_counting = 1'b0;
                    vs_meas_done = 1'b1;
                end
            end
            if (href && !prev_href && href_delay < 0 && vs_rise >= 0) href_delay = cyc - vs_rise;
        end
        prev_vs   = vsync;
        prev_href = href;
        prev_done = frame_done;
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_href", int'(href), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_href", int'(href), 0);
        chk("idle_rd_en", int'(rd_en), 0);

        // Two frames queued; enable dropped during line 3 of the second one
        push_frame();
        push_frame();
        en = 1'b1;
        repeat (112) @(negedge clk);
        en = 1'b0;
        wait_done(2);
        repeat (30) @(negedge clk);
        chk("frames_after_disable", done_seen, 2);
        chk("addr_q_drained", addr_q.size(), 0);
        chk("byte_q_drained", byte_q.size(), 0);
        chk("idle_vsync_after", int'(vsync), 0);
        chk("idle_href_after", int'(href), 0);
        chk("vsync_width", vs_len, 12);
        chk("vsync_to_href", href_delay, 24);

        // Reset in the middle of href aborts the frame
        push_frame();
        en = 1'b1;
        for (int i = 0; i < 200 && byte_q.size() > 2*NPIX - 3; i++) @(negedge clk);
        chk("reached_mid_href", int'(href), 1);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_vsync", int'(vsync), 0);
        chk("abort_href", int'(href), 0);
        chk("abort_d", int'(d), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_frame_done", int'(frame_done), 0);
        chk("abort_rd_addr", int'(rd_addr), 0);
        addr_q.delete();
        byte_q.delete();
        rdcyc_q.delete();
        first_byte = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", done_seen, 2);

        // Re-enable: addresses must restart at 0
        push_frame();
        en = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_done(3);
        repeat (20) @(negedge clk);
        chk("addr_q_drained_2", addr_q.size(), 0);
        chk("byte_q_drained_2", byte_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
